// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch FIFO producer.
package ifu_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned ENTRY_W = ADDR_W + INST_W;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_PUSH    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  // Build one FIFO entry {pc, inst}.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [ADDR_W-1:0] pc,
                                                    input logic [INST_W-1:0] inst);
    entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/i_fetch_pusher_if.sv
// Fetch producer bundle: redirect, instruction-memory handshake and FIFO write ports.
interface i_fetch_pusher_if;
  import ifu_pkg::*;

  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              fifo_stall_req;
  logic              w_ena_1;
  logic              w_ena_2;
  logic [ENTRY_W-1:0] w_data_1;
  logic [ENTRY_W-1:0] w_data_2;

  // Fetch unit side.
  modport master (
    input  flush, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, fifo_stall_req,
    output inst_req, inst_addr, w_ena_1, w_ena_2, w_data_1, w_data_2
  );

  // Memory / FIFO / pipeline-control side.
  modport slave (
    output flush, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, fifo_stall_req,
    input  inst_req, inst_addr, w_ena_1, w_ena_2, w_data_1, w_data_2
  );

endinterface

// File: rtl/i_fetch_pc.sv
// Fetch PC register: redirect on flush, otherwise step to the next 8-byte boundary.
module i_fetch_pc
  import ifu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_redirect;

  // Upper word of a pair advances by 4, lower word by 8; both land 8-byte aligned.
  always_comb begin
    w_step     = r_pc[2] ? ADDR_W'(4) : ADDR_W'(8);
    w_next_pc  = r_pc + w_step;
    w_redirect = i_redirect_pc & ~ADDR_W'(3);
  end

  // Flush outranks a push-driven advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_flush) begin
      r_pc <= w_redirect;
    end else if (i_advance) begin
      r_pc <= w_next_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/i_fetch_pusher.sv
// Instruction-fetch producer: one aligned 64-bit request at a time, split into FIFO entries.
module i_fetch_pusher
  import ifu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  i_fetch_pusher_if.master bus
);

  fetch_state_e       r_state;
  logic [ENTRY_W-1:0] r_e1;
  logic [ENTRY_W-1:0] r_e2;
  logic               r_v1;
  logic               r_v2;

  logic [ADDR_W-1:0]  w_pc;
  logic               w_push;
  logic               w_word_hi;
  logic [INST_W-1:0]  w_lo;
  logic [INST_W-1:0]  w_hi;

  i_fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (bus.flush),
    .i_redirect_pc (bus.redirect_pc),
    .i_advance     (w_push),
    .o_pc          (w_pc)
  );

  // Write-enable qualification and response word selection.
  always_comb begin
    w_push    = (r_state == S_PUSH) && r_v1 && !bus.fifo_stall_req && !bus.flush;
    w_word_hi = w_pc[2];
    w_lo      = bus.inst_rdata[INST_W-1:0];
    w_hi      = bus.inst_rdata[DATA_W-1:INST_W];
  end

  // Outputs held at zero while reset is asserted.
  assign bus.inst_req = rst_n && (r_state == S_REQ);
  assign bus.inst_addr = rst_n ? (w_pc & ~ADDR_W'(7)) : '0;
  assign bus.w_ena_1  = rst_n && w_push;
  assign bus.w_ena_2  = rst_n && w_push && r_v2;
  assign bus.w_data_1 = r_e1;
  assign bus.w_data_2 = r_e2;

  // Fetch FSM and entry buffer; flush redirects from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_e1    <= '0;
      r_e2    <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
    end else if (bus.flush) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      case (r_state)
        S_REQ:     r_state <= bus.inst_addr_ok ? S_DISCARD : S_REQ;
        S_WAIT:    r_state <= bus.inst_data_ok ? S_REQ : S_DISCARD;
        S_PUSH:    r_state <= S_REQ;
        S_DISCARD: r_state <= bus.inst_data_ok ? S_REQ : S_DISCARD;
        default:   r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (bus.inst_addr_ok) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.inst_data_ok) begin
            r_state <= S_PUSH;
            r_v1    <= 1'b1;
            r_v2    <= !w_word_hi;
            r_e1    <= pack_entry(w_pc, w_word_hi ? w_hi : w_lo);
            r_e2    <= w_word_hi ? '0 : pack_entry(w_pc + ADDR_W'(4), w_hi);
          end
        end
        S_PUSH: begin
          if (w_push) begin
            r_state <= S_REQ;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
          end
        end
        S_DISCARD: begin
          if (bus.inst_data_ok) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_i_fetch_pusher.sv
// Bench for i_fetch_pusher: directed scenarios plus randomized traffic against a transaction model.
module tb_i_fetch_pusher;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  i_fetch_pusher_if bus();

  i_fetch_pusher #(
    .RESET_PC (32'hBFC0_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        we2;
    logic [63:0] d1;
    logic [63:0] d2;
  } push_t;

  push_t       push_log[$];
  logic [31:0] acc_log[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Transaction model: fetch PC, outstanding request, pending FIFO entries.
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  logic        m_out;
  logic        m_stale;
  logic        m_pend;
  logic [63:0] m_e[2];
  int          m_nv;
  logic [31:0] m_next;

  // Memory model knobs.
  logic        mem_busy;
  int          mem_cnt;
  int          mem_lat;
  int          ok_pct;
  logic        fixed_en;
  logic [63:0] fixed_rd;
  logic        last_fl;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] get_acc(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 32'hDEAD_DEAD;
  endfunction

  function automatic push_t get_push(input int i);
    push_t p;
    p.we2 = 1'bx;
    p.d1  = 64'hDEAD_DEAD_DEAD_DEAD;
    p.d2  = 64'hDEAD_DEAD_DEAD_DEAD;
    if (i < push_log.size()) p = push_log[i];
    return p;
  endfunction

  task automatic drive_idle();
    bus.flush          = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_addr_ok   = 1'b0;
    bus.inst_data_ok   = 1'b0;
    bus.inst_rdata     = 64'h0;
    bus.fifo_stall_req = 1'b0;
  endtask

  task automatic model_reset();
    m_pc     = 32'hBFC0_0000;
    m_req_pc = 32'h0;
    m_out    = 1'b0;
    m_stale  = 1'b0;
    m_pend   = 1'b0;
    m_nv     = 0;
    m_next   = 32'h0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance the model to the next edge.
  // fmode: 0 no flush, 1 flush, 2 flush only in a cycle where a request is offered.
  task automatic step(input int fmode, input logic [31:0] redir, input logic stall);
    logic        req, acc, rsp, fl, e_we, live;
    logic [63:0] rd;
    logic [31:0] words[2];
    int          first, nwords;
    push_t       p;
    @(negedge clk);
    req = bus.inst_req;
    fl  = (fmode == 1) || (fmode == 2 && req);
    rsp = mem_busy && (mem_cnt == 0);
    rd  = fixed_en ? fixed_rd : {$urandom, $urandom};
    bus.flush          = fl;
    bus.redirect_pc    = redir;
    bus.fifo_stall_req = stall;
    bus.inst_data_ok   = rsp;
    bus.inst_rdata     = rd;
    bus.inst_addr_ok   = req && (int'($urandom_range(99)) < ok_pct);
    #1;
    acc     = req && bus.inst_addr_ok;
    last_fl = fl;

    chk("inst_req", 64'(req), 64'(!m_out && !m_pend));
    if (acc) chk("inst_addr", 64'(bus.inst_addr), 64'(m_pc & ~32'h7));
    e_we = m_pend && !stall && !fl;
    chk("w_ena_1", 64'(bus.w_ena_1), 64'(e_we));
    chk("w_ena_2", 64'(bus.w_ena_2), 64'(e_we && m_nv == 2));
    if (e_we) begin
      chk("w_data_1", bus.w_data_1, m_e[0]);
      if (m_nv == 2) chk("w_data_2", bus.w_data_2, m_e[1]);
    end
    if (bus.w_ena_1) begin
      p.we2 = bus.w_ena_2;
      p.d1  = bus.w_data_1;
      p.d2  = bus.w_data_2;
      push_log.push_back(p);
    end
    if (acc && !fl) acc_log.push_back(bus.inst_addr);

    live = rsp && !m_stale && !fl;
    if (e_we) begin
      m_pend = 1'b0;
      m_pc   = m_next;
    end
    if (rsp) begin
      m_out   = 1'b0;
      m_stale = 1'b0;
    end
    if (live) begin
      // Every instruction slot from the request PC up to the end of its 8-byte block.
      words[0] = rd[31:0];
      words[1] = rd[63:32];
      first    = int'(m_req_pc[2]);
      nwords   = (8 - int'(m_req_pc[2:0])) / 4;
      m_e[1]   = 64'h0;
      for (int k = 0; k < nwords; k++)
        m_e[k] = {m_req_pc + 32'(4 * k), words[first + k]};
      m_nv   = nwords;
      m_next = m_req_pc + 32'(4 * nwords);
      m_pend = 1'b1;
    end
    if (acc) begin
      m_out    = 1'b1;
      m_stale  = fl;
      m_req_pc = m_pc;
    end
    if (fl) begin
      if (m_out) m_stale = 1'b1;
      m_pend = 1'b0;
      m_pc   = redir & ~32'h3;
    end

    if (rsp) mem_busy = 1'b0;
    if (acc) begin
      mem_busy = 1'b1;
      mem_cnt  = ((mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat) - 1;
    end else if (mem_busy) begin
      mem_cnt--;
    end
  endtask

  // Run idle steps until a captured response is pending, bounded.
  task automatic run_to_pend(input string tag);
    int n;
    n = 0;
    while (!m_pend && n < 40) begin
      step(0, 32'h0, 1'b0);
      n++;
    end
    if (!m_pend) chk(tag, 64'd0, 64'd1);
  endtask

  initial begin
    push_t p;
    int    n;
    rst_n    = 1'b0;
    mem_lat  = 1;
    ok_pct   = 100;
    fixed_en = 1'b1;
    fixed_rd = 64'h0000_0002_0000_0001;
    last_fl  = 1'b0;
    drive_idle();
    model_reset();

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 64'(bus.inst_req), 64'd0);
    chk("rst_we1", 64'(bus.w_ena_1), 64'd0);
    chk("rst_we2", 64'(bus.w_ena_2), 64'd0);
    chk("rst_addr", 64'(bus.inst_addr), 64'd0);
    chk("rst_d1", bus.w_data_1, 64'd0);
    chk("rst_d2", bus.w_data_2, 64'd0);
    rst_n = 1'b1;

    // First fetch after reset: aligned pair.
    repeat (8) step(0, 32'h0, 1'b0);
    p = get_push(0);
    chk("A_acc0", 64'(get_acc(0)), 64'h0000_0000_BFC0_0000);
    chk("A_we2", 64'(p.we2), 64'd1);
    chk("A_d1", p.d1, 64'hBFC0_0000_0000_0001);
    chk("A_d2", p.d2, 64'hBFC0_0004_0000_0002);
    chk("A_acc1", 64'(get_acc(1)), 64'h0000_0000_BFC0_0008);

    // Redirect to an upper word: single entry, then realign.
    acc_log.delete();
    push_log.delete();
    step(1, 32'h8000_0184, 1'b0);
    repeat (8) step(0, 32'h0, 1'b0);
    p = get_push(0);
    chk("B_acc0", 64'(get_acc(0)), 64'h0000_0000_8000_0180);
    chk("B_we2", 64'(p.we2), 64'd0);
    chk("B_d1", p.d1, 64'h8000_0184_0000_0002);
    chk("B_acc1", 64'(get_acc(1)), 64'h0000_0000_8000_0188);

    // Stall for 5 cycles in PUSH: held data, then exactly one push.
    run_to_pend("C_timeout");
    push_log.delete();
    for (int i = 0; i < 5; i++) begin
      step(0, 32'h0, 1'b1);
      chk("C_hold_d1", bus.w_data_1, m_e[0]);
    end
    step(0, 32'h0, 1'b0);
    chk("C_one_push", 64'(push_log.size()), 64'd1);

    // Flush during WAIT; the stale response arrives 3 cycles later.
    mem_lat = 4;
    n = 0;
    while (!m_out && n < 40) begin
      step(0, 32'h0, 1'b0);
      n++;
    end
    if (!m_out) chk("D_timeout", 64'd0, 64'd1);
    acc_log.delete();
    push_log.delete();
    step(1, 32'h0000_1000, 1'b0);
    repeat (12) step(0, 32'h0, 1'b0);
    p = get_push(0);
    chk("D_acc0", 64'(get_acc(0)), 64'h0000_0000_0000_1000);
    chk("D_pc", 64'(p.d1[63:32]), 64'h0000_0000_0000_1000);

    // Flush in the same cycle the request is accepted.
    mem_lat = 1;
    n = 0;
    last_fl = 1'b0;
    while (!last_fl && n < 40) begin
      step(2, 32'h0000_2000, 1'b0);
      n++;
    end
    if (!last_fl) chk("E_timeout", 64'd0, 64'd1);
    acc_log.delete();
    push_log.delete();
    repeat (8) step(0, 32'h0, 1'b0);
    p = get_push(0);
    chk("E_acc0", 64'(get_acc(0)), 64'h0000_0000_0000_2000);
    chk("E_d1", p.d1, 64'h0000_2000_0000_0001);

    // Asynchronous reset in the middle of PUSH.
    run_to_pend("F_timeout");
    @(posedge clk);
    #2;
    chk("F_pre_we1", 64'(bus.w_ena_1), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("F_req", 64'(bus.inst_req), 64'd0);
    chk("F_we1", 64'(bus.w_ena_1), 64'd0);
    chk("F_we2", 64'(bus.w_ena_2), 64'd0);
    chk("F_addr", 64'(bus.inst_addr), 64'd0);
    chk("F_d1", bus.w_data_1, 64'd0);
    drive_idle();
    model_reset();
    acc_log.delete();
    push_log.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(0, 32'h0, 1'b0);
    chk("F_acc0", 64'(get_acc(0)), 64'h0000_0000_BFC0_0000);

    // Randomized traffic: latency, accept backpressure, stalls, flushes, PC wrap.
    fixed_en = 1'b0;
    mem_lat  = 0;
    ok_pct   = 70;
    for (int i = 0; i < 3000; i++) begin
      int          fm;
      logic [31:0] rp;
      fm = (int'($urandom_range(99)) < 3) ? 1 : 0;
      case ($urandom_range(3))
        0:       rp = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
        default: rp = $urandom;
      endcase
      step(fm, rp, int'($urandom_range(99)) < 30);
    end
    repeat (20) step(0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i_fetch_pusher.md
Name: i_fetch_pusher

Overview:
Producer end of the instruction FIFO write interface. Holds the fetch PC and issues one aligned 64-bit instruction-memory request at a time. Splits each response into one or two 64-bit {pc, inst} entries and pushes them through the FIFO's two write ports (w_ena_1/w_ena_2/w_data_1/w_data_2), honouring fifo_stall_req. Handles flush/redirect, including discarding an in-flight response.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch PC loaded on reset.
ADDR_W, 32, PC / address width; each entry is {pc[31:0], inst[31:0]} = 64 bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  redirect request; same cycle as the FIFO's flush.
redirect_pc  input  32  new fetch PC; valid while flush=1; bits [1:0] ignored (forced 0).
inst_req  output  1  request valid toward instruction memory.
inst_addr  output  32  request address = {pc[31:3], 3'b000}.
inst_addr_ok  input  1  request accepted this cycle when inst_req=1.
inst_data_ok  input  1  response valid; exactly one response per accepted request, in order.
inst_rdata  input  64  response data; [31:0] = word at addr, [63:32] = word at addr+4.
fifo_stall_req  input  1  FIFO cannot take writes; hold entries.
w_ena_1  output  1  write slot 1.
w_ena_2  output  1  write slot 2; never 1 unless w_ena_1=1.
w_data_1  output  64  {pc_1, inst_1}.
w_data_2  output  64  {pc_2, inst_2}.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=REQ, buffer cleared. inst_req, w_ena_1 and w_ena_2 are 0 while rst_n=0. inst_addr and w_data_* are 0 while in reset. First request asserts in the first cycle after rst_n deasserts.
- States:
  - REQ: inst_req=1, inst_addr stable. On inst_addr_ok, go to WAIT.
  - WAIT: inst_req=0. On inst_data_ok, capture the entries into the buffer, go to PUSH.
  - PUSH: buffer presented on w_data_*, w_ena_* driven = buffer valids & ~fifo_stall_req.
    - When w_ena_1=1: pc <= next_pc, go to REQ.
    - Otherwise stay in PUSH; buffer and outputs held stable.
  - DISCARD: inst_req=0. On inst_data_ok, drop the data and go to REQ (pc already redirected).
- Entry formation at capture, with addressed word index p = pc[2]:
  - p=0: e1 = {pc, rdata[31:0]}, e2 = {pc+4, rdata[63:32]}; both valid; next_pc = pc+8.
  - p=1: e1 = {pc, rdata[63:32]}; e2 invalid; next_pc = pc+4 (reaches an 8-byte-aligned PC).
- Latency: response at cycle t → push at earliest t+1. Next request at t+2 if no stall. Steady state: 2 instructions per 3 cycles plus memory latency.
- PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFF8 → 0 is allowed, with no special case.
- Flush (highest priority, synchronous), applied in every state:
  - In every state: pc <= {redirect_pc[31:2], 2'b00}; w_ena_1 and w_ena_2 forced 0 in the flush cycle; buffer invalidated.
  - REQ with inst_addr_ok=0: stay in REQ; address changes next cycle (permitted, the request was not accepted).
  - REQ with inst_addr_ok=1: go to DISCARD.
  - WAIT with inst_data_ok=0: go to DISCARD.
  - WAIT with inst_data_ok=1: response dropped, go to REQ.
  - PUSH: go to REQ.
  - DISCARD with inst_data_ok=0: stay in DISCARD.
  - DISCARD with inst_data_ok=1: go to REQ.
- fifo_stall_req rises mid-PUSH: no write occurs; entries are never lost or duplicated.
- inst_data_ok outside WAIT/DISCARD is a protocol error; ignore it (assertion in the bench).
- No combinational path from inst_rdata to w_data_*. w_ena_* depend combinationally only on state, fifo_stall_req and flush.

Decomposition:
- Shared package ifu_pkg: state encoding (REQ, WAIT, PUSH, DISCARD), ENTRY_W=64, RESET_PC default, entry-pack function {pc, inst}.
- One natural sub-module: i_fetch_pc (PC register, next_pc / redirect mux, async reset). FSM and buffer stay in i_fetch_pusher.

Test Plan:
- Reset release; memory answers 1 cycle after accept with 64'h0000_0002_0000_0001 → inst_addr=BFC0_0000; w_data_1={BFC0_0000, 1}, w_data_2={BFC0_0004, 2} with both enables; next inst_addr=BFC0_0008.
- flush with redirect_pc=8000_0184 → inst_addr=8000_0180; only w_ena_1, w_data_1={8000_0184, rdata[63:32]}; next inst_addr=8000_0188.
- fifo_stall_req=1 for 5 cycles while in PUSH → w_ena_*=0 and w_data_* stable for those 5 cycles; exactly one push when stall drops.
- flush during WAIT (redirect 0000_1000), then stale data_ok 3 cycles later → no w_ena from the stale data; next request to 0000_1000.
- flush coincident with inst_addr_ok in REQ → DISCARD entered; the single following response is dropped.
- rst_n pulsed low mid-PUSH → outputs 0 immediately (async); restart at RESET_PC.
